// File: rtl/serial_io_pkg.sv
// Shared types and helpers for the serial I/O chain controller.
package serial_io_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Frame length: long enough to shift out every output bit and capture every input bit.
  function automatic int frame_len(input int out_w, input int in_w);
    return (out_w > in_w) ? out_w : in_w;
  endfunction

endpackage

// File: rtl/sio_tick_gen.sv
// Serial clock divider: emits one tick every CLK_DIV enabled cycles, held at zero while disabled.
module sio_tick_gen #(
  parameter int CLK_DIV = 2048
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter: wraps at CLK_DIV-1, forced back to zero whenever the chain is not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!en) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/serial_io_chain.sv
// Serial I/O chain controller: shifts a parallel word out LSB first on smosi while
// capturing smiso, then pulses sld and publishes the captured word with change detection.
module serial_io_chain
  import serial_io_pkg::*;
#(
  parameter int OUT_W   = 16,
  parameter int IN_W    = 16,
  parameter int CLK_DIV = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OUT_W-1:0] out_data,
  input  logic             out_valid,
  output logic             out_ready,
  input  logic             cont_en,
  output logic [IN_W-1:0]  in_data,
  output logic             in_valid,
  output logic             in_changed,
  input  logic             irq_en,
  input  logic             irq_clr,
  output logic             irq,
  output logic             busy,
  output logic             sclk,
  output logic             sld,
  output logic             smosi,
  input  logic             smiso
);

  localparam int N  = frame_len(OUT_W, IN_W);
  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t           state_r;
  state_t           state_s;
  logic             tick_s;
  logic             last_bit_s;
  logic [OUT_W-1:0] held_r;
  logic [N-1:0]     out_sh_r;
  logic [N-1:0]     out_nxt_s;
  logic [N-1:0]     in_sh_r;
  logic [IN_W-1:0]  in_cap_s;
  logic [BW-1:0]    bit_cnt_r;
  logic [IN_W-1:0]  in_data_r;
  logic             in_valid_r;
  logic             in_changed_r;
  logic             irq_r;
  logic             sclk_r;
  logic             sld_r;
  logic             smosi_r;

  sio_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_r == SHIFT) || (state_r == LATCH)),
    .tick (tick_s)
  );

  // The final falling serial edge of the frame ends the shift phase.
  assign last_bit_s = tick_s && sclk_r && (bit_cnt_r == LAST_BIT);
  assign out_nxt_s  = out_sh_r >> 1;
  assign in_cap_s   = in_sh_r[N-1 -: IN_W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a new word has priority over re-sending the held word.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (out_valid || cont_en) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_s = LATCH;
        end else begin
          state_s = SHIFT;
        end
      end
      LATCH: begin
        if (tick_s) begin
          state_s = IDLE;
        end else begin
          state_s = LATCH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Frame datapath: word capture, shifters, serial pins and end-of-frame publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r       <= '0;
      out_sh_r     <= '0;
      in_sh_r      <= '0;
      bit_cnt_r    <= '0;
      in_data_r    <= '0;
      in_valid_r   <= 1'b0;
      in_changed_r <= 1'b0;
      sclk_r       <= 1'b0;
      sld_r        <= 1'b0;
      smosi_r      <= 1'b0;
    end else begin
      in_valid_r   <= 1'b0;
      in_changed_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (out_valid) begin
            held_r <= out_data;
          end
        end
        LOAD: begin
          out_sh_r  <= N'(held_r);
          in_sh_r   <= '0;
          bit_cnt_r <= '0;
          smosi_r   <= held_r[0];
        end
        SHIFT: begin
          if (tick_s) begin
            sclk_r <= ~sclk_r;
            if (!sclk_r) begin
              // Rising serial edge: sample smiso into the MSB, older samples move down.
              in_sh_r <= (in_sh_r >> 1) | (N'(smiso) << (N - 1));
            end else begin
              // Falling serial edge: present the next output bit.
              out_sh_r  <= out_nxt_s;
              smosi_r   <= out_nxt_s[0];
              bit_cnt_r <= bit_cnt_r + BW'(1);
              if (bit_cnt_r == LAST_BIT) begin
                sld_r <= 1'b1;
              end
            end
          end
        end
        LATCH: begin
          if (tick_s) begin
            sld_r        <= 1'b0;
            in_data_r    <= in_cap_s;
            in_valid_r   <= 1'b1;
            in_changed_r <= (in_cap_s != in_data_r);
          end
        end
        default: begin
          sld_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky change interrupt; a new set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else if (in_changed_r && irq_en) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign out_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign in_data    = in_data_r;
  assign in_valid   = in_valid_r;
  assign in_changed = in_changed_r;
  assign irq        = irq_r;
  assign sclk       = sclk_r;
  assign sld        = sld_r;
  assign smosi      = smosi_r;

endmodule

// File: tb/tb_serial_io_chain.sv
// Scoreboard bench for serial_io_chain (16/16 bits, CLK_DIV=2).
module tb_serial_io_chain;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    logic        chg;
    logic        b2b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cont_en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_changed;
  logic        irq_en;
  logic        irq_clr;
  logic        irq;
  logic        busy;
  logic        sclk;
  logic        sld;
  logic        smosi;
  logic        smiso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iv_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_iv_cyc = -100;
  int nbits = 0;
  int ridx = 0;
  int sld_cnt = 0;
  int ready_bad = 0;
  logic [15:0] tx_bits = 16'h0000;
  logic [15:0] cur_miso = 16'h0000;
  logic prev_sclk = 1'b0;
  logic prev_busy = 1'b0;
  exp_t exp_q[$];
  logic [15:0] miso_q[$];
  exp_t e;

  serial_io_chain #(.OUT_W(16), .IN_W(16), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cont_en(cont_en), .in_data(in_data),
    .in_valid(in_valid), .in_changed(in_changed), .irq_en(irq_en),
    .irq_clr(irq_clr), .irq(irq), .busy(busy), .sclk(sclk), .sld(sld),
    .smosi(smosi), .smiso(smiso)
  );

  always #5 clk = ~clk;

  // Posedge counter used for latency and gap measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: models the serial chain (smiso source, smosi sink) and scores each published word.
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; tx_bits = 16'h0000; sld_cnt = 0; ridx = 0;
      prev_sclk = 1'b0; prev_busy = 1'b0; smiso = 1'b0;
    end else begin
      if (in_valid) begin
        iv_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_in_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("in_data", in_data, e.rx);
          chk("in_changed", in_changed, e.chg);
          chk("smosi_word", tx_bits, e.tx);
          chk("smosi_bits", nbits, 16);
          chk("sld_cycles", sld_cnt, 2);
          // edges from the accepting edge to the edge that raises in_valid
          chk("latency", cyc - (start_cyc + 1), 67);
        end
        last_iv_cyc = cyc; nbits = 0; tx_bits = 16'h0000; sld_cnt = 0;
      end else if (in_changed) begin
        chk("in_changed_without_in_valid", 32'd1, 32'd0);
      end
      if (out_ready && (out_valid || cont_en)) begin
        start_cyc = cyc;
        start_cnt++;
        if (exp_q.size() > 0 && exp_q[0].b2b) chk("idle_gap", cyc, last_iv_cyc);
      end
      if (busy && !prev_busy) begin
        cur_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 16'h0000;
        ridx = 0;
        smiso = cur_miso[0];
      end
      if (sclk && !prev_sclk) begin
        if (nbits < 16) tx_bits[nbits] = smosi;
        nbits++;
        ridx++;
        smiso = (ridx < 16) ? cur_miso[ridx] : 1'b0;
      end
      if (sld) sld_cnt++;
      if (out_ready == busy) ready_bad++;
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the DUT takes it; reports waiting cycles.
  task automatic accept(input logic [15:0] tx, output int waited, output logic iv_seen);
    out_data = tx;
    out_valid = 1'b1;
    waited = 0;
    while (!out_ready && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    iv_seen = in_valid;
    chk("accept_ready", out_ready, 1'b1);
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] tx, input logic [15:0] rx, input logic chg);
    int w;
    logic ivs;
    exp_q.push_back('{tx, rx, chg, 1'b0});
    miso_q.push_back(rx);
    accept(tx, w, ivs);
  endtask

  task automatic wait_iv(input int target);
    for (int i = 0; i < 3000 && iv_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk("in_valid_count", iv_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic ivs;
    rst = 1'b1; out_data = 16'h0000; out_valid = 1'b0; cont_en = 1'b0;
    irq_en = 1'b0; irq_clr = 1'b0;
    wait_cycles(3);
    chk("reset_pins", {sclk, sld, smosi, busy, out_ready, in_valid, in_changed, irq}, 8'b0000_1000);
    chk("reset_in_data", in_data, 16'h0000);
    rst = 1'b0;
    wait_cycles(2);

    // Scenario 1: first frame, input changes from the reset value.
    send_frame(16'hA5C3, 16'h1234, 1'b1);
    wait_iv(1);
    chk("s1_irq", irq, 1'b0);

    // Scenario 2: identical input, no change reported.
    send_frame(16'hA5C3, 16'h1234, 1'b0);
    wait_iv(2);
    chk("s2_irq", irq, 1'b0);

    // Scenario 3: change interrupt set, clear, and set-beats-clear.
    irq_en = 1'b1;
    send_frame(16'h0F00, 16'h1235, 1'b1);
    wait_iv(3);
    chk("s3_irq_set", irq, 1'b1);
    irq_clr = 1'b1;
    wait_cycles(1);
    irq_clr = 1'b0;
    chk("s3_irq_clr", irq, 1'b0);
    send_frame(16'h0F00, 16'h1234, 1'b1);
    for (int i = 0; i < 3000 && !in_changed; i++) begin
      @(posedge clk); #1;
    end
    irq_clr = 1'b1;
    wait_cycles(1);
    irq_clr = 1'b0;
    chk("s3_irq_set_wins", irq, 1'b1);
    wait_iv(4);
    irq_en = 1'b0;
    irq_clr = 1'b1;
    wait_cycles(1);
    irq_clr = 1'b0;

    // Scenario 4: word offered while busy is taken in the first IDLE cycle.
    send_frame(16'h1111, 16'h1234, 1'b0);
    wait_cycles(10);
    exp_q.push_back('{16'h00FF, 16'h0F0F, 1'b1, 1'b1});
    miso_q.push_back(16'h0F0F);
    accept(16'h00FF, w, ivs);
    chk("s4_waited_while_busy", (w > 40) ? 32'd1 : 32'd0, 32'd1);
    chk("s4_first_idle", ivs, 1'b1);
    wait_iv(6);

    // Scenario 5: reset in the middle of a frame discards it.
    miso_q.push_back(16'hAAAA);
    accept(16'hFFFF, w, ivs);
    for (int i = 0; i < 3000 && nbits < 7; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    wait_cycles(1);
    chk("s5_pins", {sclk, sld, smosi, busy, out_ready, in_valid, in_changed, irq}, 8'b0000_1000);
    chk("s5_in_data", in_data, 16'h0000);
    rst = 1'b0;
    wait_cycles(150);
    chk("s5_no_in_valid", iv_cnt, 6);

    // Scenario 6: continuous refresh re-sends the held word back to back.
    base = start_cnt;
    exp_q.push_back('{16'h5A5A, 16'h0001, 1'b1, 1'b0});
    exp_q.push_back('{16'h5A5A, 16'h0001, 1'b0, 1'b1});
    exp_q.push_back('{16'h5A5A, 16'h8000, 1'b1, 1'b1});
    miso_q.push_back(16'h0001);
    miso_q.push_back(16'h0001);
    miso_q.push_back(16'h8000);
    cont_en = 1'b1;
    accept(16'h5A5A, w, ivs);
    for (int i = 0; i < 3000 && start_cnt < base + 3; i++) begin
      @(posedge clk); #1;
    end
    cont_en = 1'b0;
    wait_iv(9);
    wait_cycles(100);
    chk("s6_frames", start_cnt - base, 3);
    chk("s6_in_valid_total", iv_cnt, 9);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("ready_busy_exclusive", ready_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_io_chain.md
SERIAL_IO_CHAIN -- requirements
Module: serial_io_chain

Interface
REQ-001 SHALL have parameter OUT_W, default 16: number of bits shifted out per frame.
REQ-002 SHALL have parameter IN_W, default 16: number of bits captured per frame.
REQ-003 SHALL have parameter CLK_DIV, default 2048: clk cycles per serial half-period; legal range is >=1.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port out_data, input, OUT_W: parallel word to shift out.
REQ-007 SHALL have ports out_valid (input, 1) and out_ready (output, 1): valid/ready word handshake.
REQ-008 SHALL have port cont_en, input, 1: continuous-refresh enable.
REQ-009 SHALL have port in_data, output, IN_W: last captured input word.
REQ-010 SHALL have ports in_valid (output, 1) and in_changed (output, 1): one-cycle pulses at frame end.
REQ-011 SHALL have ports irq_en (input, 1), irq_clr (input, 1) and irq (output, 1): sticky change interrupt.
REQ-012 SHALL have port busy, output, 1: frame in progress.
REQ-013 SHALL have ports sclk, sld and smosi (outputs, 1 each) and smiso (input, 1): serial chain pins.

Function
REQ-014 Frame length N SHALL be max(OUT_W, IN_W); bit counter width SHALL be clog2(N+1).
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT and LATCH; out_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in all other states.
REQ-016 IDLE SHALL go to LOAD when out_valid is 1, capturing out_data into a held word; out_valid SHALL take priority over cont_en.
REQ-017 IDLE with out_valid=0 and cont_en=1 SHALL go to LOAD, re-sending the held word (0 after reset).
REQ-018 LOAD SHALL last 1 cycle: copy the held word into the shifter, zero-extend to N, clear the bit counter, drive smosi with bit 0, then go to SHIFT.
REQ-019 The divider SHALL count 0..CLK_DIV-1 only while in SHIFT or LATCH, SHALL emit tick at CLK_DIV-1, and SHALL be held at 0 otherwise.
REQ-020 In SHIFT, each tick SHALL toggle sclk.
REQ-021 On each 0->1 toggle, smiso SHALL shift into the input shifter at its MSB (shift right).
REQ-022 On each 1->0 toggle, the output shifter SHALL shift right (LSB first), smosi SHALL show the next bit, and the bit counter SHALL increment.
REQ-023 After the Nth 1->0 toggle, the FSM SHALL go to LATCH.
REQ-024 LATCH SHALL drive sld=1 for exactly CLK_DIV cycles and then go to IDLE.
REQ-025 On the LATCH->IDLE transition, in_data SHALL load the input shifter so that in_data[k] = sample number (N-IN_W+k); in_valid SHALL pulse 1 cycle at the same time.
REQ-026 in_changed SHALL pulse together with in_valid only when the new in_data differs from the previous in_data.
REQ-027 irq SHALL be set when in_changed=1 and irq_en=1, and cleared by irq_clr; when set and clear occur in the same cycle, set SHALL win.
REQ-028 Latency from the acceptance cycle to in_valid SHALL be 1 + 2*N*CLK_DIV + CLK_DIV cycles.
REQ-029 In continuous mode, the gap between frames SHALL be exactly 1 IDLE cycle.
REQ-030 sclk, sld and smosi SHALL be registered outputs with no combinational path from any input.
REQ-031 out_valid while busy SHALL be ignored, with no queuing; the word SHALL be accepted in the next IDLE cycle if it is still valid.

Reset
REQ-032 rst SHALL force the following within 1 cycle, including mid-frame: state=IDLE, sclk=0, sld=0, smosi=0, busy=0, out_ready=1, in_valid=0, in_changed=0, irq=0, in_data=0, held word=0, divider=0, shifters=0.
REQ-033 A partial frame interrupted by rst SHALL be discarded.

Structure
REQ-034 A shared package serial_io_pkg SHALL hold the state enum and a frame-length function max(OUT_W, IN_W).
REQ-035 The divider SHALL be a sub-module sio_tick_gen with parameter CLK_DIV and ports clk, rst, en, tick.

Verification (OUT_W=16, IN_W=16, CLK_DIV=2)
REQ-036 Scenario 1: accept 0xA5C3 with smiso modelling input 0x1234 -> smosi bits LSB first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; in_data=0x1234; in_valid pulses once, 67 cycles after acceptance; sld high for 2 cycles.
REQ-037 Scenario 2: repeat the frame with the same input -> in_valid=1, in_changed=0, irq=0.
REQ-038 Scenario 3: input 0x1235 with irq_en=1 -> in_changed pulse and irq=1; irq_clr alone -> irq=0; irq_clr in the same cycle as a new set -> irq stays 1.
REQ-039 Scenario 4: out_valid held with 0x00FF during a busy frame -> out_ready=0 throughout; the word is accepted in the first IDLE cycle, and the following frame sends 0x00FF.
REQ-040 Scenario 5: rst asserted after the 7th bit -> the next cycle shows sclk=0, sld=0, busy=0, out_ready=1, in_data=0, and in_valid never pulses.
REQ-041 Scenario 6: cont_en=1 after one accepted 0x5A5A -> back-to-back frames each send 0x5A5A with a 1-cycle IDLE gap and one in_valid per frame.
